// File: rtl/lcd_fb_pkg.sv
// Shared constants and types for the LCD frame-buffer write sequencer.
package lcd_fb_pkg;

    localparam int unsigned NPIX = 160 * 144;
    localparam int unsigned AW   = 15;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2,
        CLEAR  = 2'd3
    } fb_state_e;

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

endpackage

// File: rtl/lcd_fb_addr_ctr.sv
// Frame-buffer write pointer shared by the pixel and clear paths; wraps to 0 after N-1.
module lcd_fb_addr_ctr
    import lcd_fb_pkg::*;
#(
    parameter int unsigned N = NPIX
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [AW-1:0] o_ptr,
    output logic          o_tc
);

    logic [AW-1:0] r_ptr;

    assign o_ptr = r_ptr;
    assign o_tc  = (r_ptr == AW'(N - 1));

    // Clear wins over enable so a write can use the current pointer while the frame restarts.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= o_tc ? '0 : r_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_fb_ctrl.sv
// Write-side sequencer for the double-banked LCD frame buffer: pixel writes,
// bank swapping on completed frames and a blanking clear when the LCD turns off.
module lcd_fb_ctrl
    import lcd_fb_pkg::*;
#(
    parameter int unsigned   WIDTH  = 160,
    parameter int unsigned   HEIGHT = 144,
    parameter int unsigned   DW     = 15,
    parameter logic [DW-1:0] BLANK  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic [DW-1:0] pix_data,
    input  logic [1:0]    mode,
    input  logic          lcd_on,
    output logic [AW-1:0] fb_addr,
    output logic [DW-1:0] fb_data,
    output logic          fb_we,
    output logic          fb_wbank,
    output logic          disp_bank,
    output logic          frame_done,
    output logic          short_frame,
    output logic          drop,
    output logic          clearing
);

    localparam int unsigned NPIX_L = WIDTH * HEIGHT;

    fb_state_e     r_state;
    fb_state_e     w_state_nx;
    logic [1:0]    r_prev_mode;
    logic          r_skip_first;
    logic          r_pix_last_d;
    logic          r_clr_last_d;

    logic [AW-1:0] r_fb_addr;
    logic [DW-1:0] r_fb_data;
    logic          r_fb_we;
    logic          r_fb_wbank;
    logic          r_disp_bank;
    logic          r_frame_done;
    logic          r_short_frame;
    logic          r_drop;
    logic          r_clearing;

    logic [AW-1:0] w_ptr;
    logic          w_tc;
    logic          w_ctr_clr;
    logic          w_ctr_en;
    logic          w_vb_rise;
    logic          w_we;
    logic [DW-1:0] w_data;
    logic          w_short;
    logic          w_drop;
    logic          w_pix_last;
    logic          w_clr_last;
    logic          w_set_skip;
    logic          w_swap;

    lcd_fb_addr_ctr #(.N(NPIX_L)) u_ctr (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (w_ctr_clr),
        .i_en    (w_ctr_en),
        .o_ptr   (w_ptr),
        .o_tc    (w_tc)
    );

    assign w_vb_rise = (mode == MODE_VBLANK) && (r_prev_mode != MODE_VBLANK);
    assign w_swap    = r_clr_last_d || (r_pix_last_d && !r_skip_first);

    always_comb begin
        w_state_nx = r_state;
        w_ctr_clr  = 1'b0;
        w_ctr_en   = 1'b0;
        w_we       = 1'b0;
        w_data     = pix_data;
        w_short    = 1'b0;
        w_drop     = 1'b0;
        w_pix_last = 1'b0;
        w_clr_last = 1'b0;
        w_set_skip = 1'b0;
        case (r_state)
            OFF: begin
                w_drop = ce;
                if (lcd_on) begin
                    w_state_nx = ACTIVE;
                    w_ctr_clr  = 1'b1;
                    w_set_skip = 1'b1;
                end
            end
            ACTIVE: begin
                if (!lcd_on) begin
                    w_drop     = ce;
                    w_state_nx = CLEAR;
                    w_ctr_clr  = 1'b1;
                end else if (ce) begin
                    w_we     = 1'b1;
                    w_ctr_en = 1'b1;
                    if (w_tc) begin
                        w_state_nx = FULL;
                        w_pix_last = 1'b1;
                    end else if (w_vb_rise) begin
                        w_ctr_clr = 1'b1;
                        w_short   = 1'b1;
                    end
                end else if (w_vb_rise && (w_ptr != '0)) begin
                    w_ctr_clr = 1'b1;
                    w_short   = 1'b1;
                end
            end
            FULL: begin
                w_drop = ce;
                if (!lcd_on) begin
                    w_state_nx = CLEAR;
                    w_ctr_clr  = 1'b1;
                end else if (w_vb_rise) begin
                    w_state_nx = ACTIVE;
                    w_ctr_clr  = 1'b1;
                end
            end
            CLEAR: begin
                w_drop   = ce;
                w_we     = 1'b1;
                w_data   = BLANK;
                w_ctr_en = 1'b1;
                if (w_tc) begin
                    w_clr_last = 1'b1;
                    if (lcd_on) begin
                        w_state_nx = ACTIVE;
                        w_set_skip = 1'b1;
                    end else begin
                        w_state_nx = OFF;
                    end
                end
            end
            default: w_state_nx = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= OFF;
            r_prev_mode   <= MODE_HBLANK;
            r_skip_first  <= 1'b1;
            r_pix_last_d  <= 1'b0;
            r_clr_last_d  <= 1'b0;
            r_fb_addr     <= '0;
            r_fb_data     <= '0;
            r_fb_we       <= 1'b0;
            r_fb_wbank    <= 1'b0;
            r_disp_bank   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            r_drop        <= 1'b0;
            r_clearing    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_prev_mode   <= mode;
            r_pix_last_d  <= w_pix_last;
            r_clr_last_d  <= w_clr_last;
            r_fb_addr     <= w_ptr;
            r_fb_data     <= w_data;
            r_fb_we       <= w_we;
            // Target the bank that will be the back bank once any swap on this edge lands.
            r_fb_wbank    <= ~(r_disp_bank ^ w_swap);
            r_disp_bank   <= r_disp_bank ^ w_swap;
            r_frame_done  <= w_swap;
            r_short_frame <= w_short;
            r_drop        <= w_drop;
            r_clearing    <= (r_state == CLEAR);
            if (w_set_skip) begin
                r_skip_first <= 1'b1;
            end else if (r_pix_last_d) begin
                r_skip_first <= 1'b0;
            end
        end
    end

    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign fb_we       = r_fb_we;
    assign fb_wbank    = r_fb_wbank;
    assign disp_bank   = r_disp_bank;
    assign frame_done  = r_frame_done;
    assign short_frame = r_short_frame;
    assign drop        = r_drop;
    assign clearing    = r_clearing;

endmodule

// File: tb/tb_lcd_fb_ctrl.sv
// Randomized bench for lcd_fb_ctrl against a frame-level reference model.
module tb_lcd_fb_ctrl;

    localparam int unsigned NPIX = 23040;
    localparam int unsigned DW   = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic [DW-1:0] pix_data;
    logic [1:0]    mode;
    logic          lcd_on;
    logic [14:0]   fb_addr;
    logic [DW-1:0] fb_data;
    logic          fb_we;
    logic          fb_wbank;
    logic          disp_bank;
    logic          frame_done;
    logic          short_frame;
    logic          drop;
    logic          clearing;

    lcd_fb_ctrl #(.WIDTH(160), .HEIGHT(144), .DW(DW), .BLANK(15'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .pix_data    (pix_data),
        .mode        (mode),
        .lcd_on      (lcd_on),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_wbank    (fb_wbank),
        .disp_bank   (disp_bank),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .drop        (drop),
        .clearing    (clearing)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: 0 = dark, 1 = filling a frame, 2 = frame complete, 3 = blanking.
    int unsigned m_phase     = 0;
    int unsigned m_count     = 0;
    bit          m_disp      = 1'b0;
    bit          m_skip      = 1'b1;
    logic [1:0]  m_prev_mode = 2'b00;
    int unsigned m_swap_kind = 0;

    bit          e_we = 0, e_wbank = 0, e_fd = 0, e_short = 0, e_drop = 0, e_clr = 0;
    int unsigned e_addr = 0;
    logic [DW-1:0] e_data = '0;

    task automatic model_write(input logic [DW-1:0] d);
        e_we    = 1'b1;
        e_addr  = m_count;
        e_data  = d;
        e_wbank = !m_disp;
    endtask

    task automatic model_step();
        bit          vb;
        int unsigned kind_nx;
        kind_nx = 0;
        if (reset) begin
            m_phase = 0; m_count = 0; m_disp = 0; m_skip = 1;
            m_prev_mode = 2'b00; m_swap_kind = 0;
            e_we = 0; e_wbank = 0; e_fd = 0; e_short = 0; e_drop = 0; e_clr = 0;
            return;
        end
        vb = (mode == 2'b01) && (m_prev_mode != 2'b01);
        m_prev_mode = mode;
        e_we = 0; e_fd = 0; e_short = 0; e_drop = 0;
        if (m_swap_kind == 2 || (m_swap_kind == 1 && !m_skip)) begin
            m_disp = !m_disp;
            e_fd   = 1'b1;
        end else if (m_swap_kind == 1) begin
            m_skip = 1'b0;
        end
        e_clr = (m_phase == 3);
        case (m_phase)
            0: begin
                e_drop = ce;
                if (lcd_on) begin m_phase = 1; m_count = 0; m_skip = 1; end
            end
            1: begin
                if (!lcd_on) begin
                    e_drop = ce; m_phase = 3; m_count = 0;
                end else if (ce) begin
                    model_write(pix_data);
                    if (m_count == NPIX - 1) begin
                        m_count = 0; m_phase = 2; kind_nx = 1;
                    end else if (vb) begin
                        m_count = 0; e_short = 1;
                    end else begin
                        m_count++;
                    end
                end else if (vb && m_count != 0) begin
                    m_count = 0; e_short = 1;
                end
            end
            2: begin
                e_drop = ce;
                if (!lcd_on) begin m_phase = 3; m_count = 0; end
                else if (vb) begin m_phase = 1; m_count = 0; end
            end
            default: begin
                e_drop = ce;
                model_write('0);
                if (m_count == NPIX - 1) begin
                    m_count = 0; kind_nx = 2;
                    if (lcd_on) begin m_phase = 1; m_skip = 1; end
                    else m_phase = 0;
                end else begin
                    m_count++;
                end
            end
        endcase
        m_swap_kind = kind_nx;
    endtask

    task automatic compare_all();
        chk("fb_we", fb_we, e_we);
        chk("disp_bank", disp_bank, e_disp_now());
        chk("frame_done", frame_done, e_fd);
        chk("short_frame", short_frame, e_short);
        chk("drop", drop, e_drop);
        chk("clearing", clearing, e_clr);
        if (e_we) begin
            chk("fb_addr", fb_addr, e_addr);
            chk("fb_data", fb_data, e_data);
            chk("fb_wbank", fb_wbank, e_wbank);
        end
    endtask

    function automatic bit e_disp_now();
        return m_disp;
    endfunction

    task automatic cyc(input logic c, input logic [1:0] m, input logic on);
        ce       = c;
        pix_data = DW'($urandom);
        mode     = m;
        lcd_on   = on;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [1:0] rnd_mode();
        int unsigned r;
        r = $urandom_range(2);
        return (r == 0) ? 2'b00 : 2'(r + 1);
    endfunction

    function automatic logic rnd_ce();
        return ($urandom_range(255) != 0);
    endfunction

    task automatic run_frame();
        int unsigned g;
        g = 0;
        while (m_phase == 1 && g < 30000) begin
            cyc(rnd_ce(), rnd_mode(), 1'b1);
            g++;
        end
        if (g >= 30000) begin
            $display("FAIL frame_bound: got %0d cycles expected < 30000", g);
            $fatal(1);
        end
    endtask

    initial begin
        reset = 1'b1; ce = 1'b0; pix_data = '0; mode = 2'b00; lcd_on = 1'b0;
        repeat (3) cyc(1'b0, 2'b00, 1'b0);
        chk("reset_we", fb_we, 1'b0);
        chk("reset_disp", disp_bank, 1'b0);
        reset = 1'b0;
        repeat (3) cyc(rnd_ce(), rnd_mode(), 1'b0);

        // First frame after enable completes without a swap.
        cyc(1'b0, 2'b00, 1'b1);
        run_frame();
        repeat (5) cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b0, 2'b01, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);

        // Second frame swaps.
        run_frame();
        repeat (4) cyc(1'b0, rnd_mode(), 1'b1);
        chk("disp_after_f2", disp_bank, 1'b1);
        cyc(1'b0, 2'b01, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);

        // Short frame, then ce coinciding with vblank entry.
        repeat (100) cyc(1'b1, rnd_mode(), 1'b1);
        cyc(1'b0, 2'b01, 1'b1);
        cyc(1'b1, 2'b00, 1'b1);
        repeat (49) cyc(1'b1, rnd_mode(), 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);

        // Switch off at ptr 500; re-enable part-way through the clear.
        repeat (500) cyc(1'b1, rnd_mode(), 1'b1);
        cyc(rnd_ce(), rnd_mode(), 1'b0);
        for (int k = 0; k < 24000 && m_phase == 3; k++) begin
            cyc(rnd_ce(), rnd_mode(), (k >= 1000));
        end
        chk("relaunch_active", m_phase, 1);
        repeat (300) cyc(rnd_ce(), rnd_mode(), 1'b1);

        // Reset in the middle of a clear.
        cyc(1'b0, 2'b00, 1'b0);
        repeat (7000) cyc(rnd_ce(), rnd_mode(), 1'b0);
        chk("clear_midway", clearing, 1'b1);
        reset = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        chk("rst_mid_we", fb_we, 1'b0);
        chk("rst_mid_clearing", clearing, 1'b0);
        chk("rst_mid_disp", disp_bank, 1'b0);
        reset = 1'b0;
        repeat (10) cyc(rnd_ce(), rnd_mode(), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
